// File: rtl/darkuart_arb_pkg.sv
// rtl/darkuart_arb_pkg.sv - shared encodings for the darkuart two-master arbiter
// Holds the sequencer state encoding, master index constants and the default
// read latency used by darkuart_arb.
package darkuart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int RD_LAT_DEF = 1;

endpackage

// File: rtl/darkuart_arb_rr.sv
// rtl/darkuart_arb_rr.sv - two-input round-robin picker
// Ports:
//   req  : raw requests, bit n = master n
//   hold : masters excluded this cycle (just acknowledged)
//   last : index of the master granted most recently
//   gnt  : one-hot pick, 00 when nobody eligible
module rr_arb2 (
   input  logic [1:0] req,
   input  logic [1:0] hold,
   input  logic       last,
   output logic [1:0] gnt
);

   logic [1:0] eligible;

   always_comb begin
      eligible = req & ~hold;
      gnt      = eligible;
      // On a tie the master that did not go last wins.
      if (eligible == 2'b11) begin
         gnt = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/darkuart_arb.sv
// rtl/darkuart_arb.sv - shares the darkuart register port between two masters
// Ports:
//   clk, res             : clock, asynchronous active-low reset
//   mN_rd/wr/be/datai    : master N request (held until mN_ack), write wins over read
//   mN_datao, mN_ack     : read data (held until next ack), one-cycle completion
//   mN_irq               : combinational copy of u_irq
//   u_rd/u_wr/u_be/u_datai, u_datao, u_irq : darkuart register interface
//   grant, busy          : current owner (one-hot), sequencer not idle
module darkuart_arb
   import darkuart_arb_pkg::*;
#(
   parameter int RD_LAT = RD_LAT_DEF,
   parameter int DW     = 32
) (
   input  logic          clk,
   input  logic          res,
   input  logic          m0_rd,
   input  logic          m0_wr,
   input  logic [3:0]    m0_be,
   input  logic [DW-1:0] m0_datai,
   output logic [DW-1:0] m0_datao,
   output logic          m0_ack,
   output logic          m0_irq,
   input  logic          m1_rd,
   input  logic          m1_wr,
   input  logic [3:0]    m1_be,
   input  logic [DW-1:0] m1_datai,
   output logic [DW-1:0] m1_datao,
   output logic          m1_ack,
   output logic          m1_irq,
   output logic          u_rd,
   output logic          u_wr,
   output logic [3:0]    u_be,
   output logic [DW-1:0] u_datai,
   input  logic [DW-1:0] u_datao,
   input  logic          u_irq,
   output logic [1:0]    grant,
   output logic          busy
);

   state_t     state;
   logic [1:0] hold;
   logic       last;
   logic       own;
   logic       cmd_wr;
   logic [2:0] cnt;
   logic [1:0] req;
   logic [1:0] gnt;

   assign req    = {m1_rd | m1_wr, m0_rd | m0_wr};
   assign m0_irq = u_irq;
   assign m1_irq = u_irq;

   rr_arb2 u_rr (
      .req  (req),
      .hold (hold),
      .last (last),
      .gnt  (gnt)
   );

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state    <= IDLE;
         hold     <= 2'b00;
         last     <= M1;
         own      <= M0;
         cmd_wr   <= 1'b0;
         cnt      <= 3'd0;
         u_rd     <= 1'b0;
         u_wr     <= 1'b0;
         u_be     <= 4'd0;
         u_datai  <= '0;
         m0_datao <= '0;
         m1_datao <= '0;
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         grant    <= 2'b00;
         busy     <= 1'b0;
      end else begin
         // Strobes and acks are single-cycle unless set below.
         u_rd   <= 1'b0;
         u_wr   <= 1'b0;
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         case (state)
            IDLE: begin
               hold <= 2'b00;
               if (gnt != 2'b00) begin
                  own   <= gnt[1];
                  last  <= gnt[1];
                  grant <= gnt;
                  busy  <= 1'b1;
                  state <= ISSUE;
                  // The command register doubles as the u_be/u_datai drivers,
                  // so they keep their value once the strobe has gone.
                  if (gnt[1]) begin
                     cmd_wr  <= m1_wr;
                     u_wr    <= m1_wr;
                     u_rd    <= ~m1_wr;
                     u_be    <= m1_be;
                     u_datai <= m1_datai;
                  end else begin
                     cmd_wr  <= m0_wr;
                     u_wr    <= m0_wr;
                     u_rd    <= ~m0_wr;
                     u_be    <= m0_be;
                     u_datai <= m0_datai;
                  end
               end
            end
            ISSUE: begin
               if (cmd_wr || RD_LAT == 0) begin
                  if (!cmd_wr) begin
                     if (own) m1_datao <= u_datao;
                     else     m0_datao <= u_datao;
                  end
                  m0_ack <= ~own;
                  m1_ack <= own;
                  state  <= ACK;
               end else begin
                  cnt   <= 3'(RD_LAT - 1);
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 3'd0) begin
                  if (own) m1_datao <= u_datao;
                  else     m0_datao <= u_datao;
                  m0_ack <= ~own;
                  m1_ack <= own;
                  state  <= ACK;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            ACK: begin
               // Mask the finishing master for one IDLE cycle so a request
               // it has not dropped yet is not granted again.
               hold  <= grant;
               grant <= 2'b00;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
